id_scoreboard: RTL and testbench

- Parametrised decode-stage hazard unit that replaces fixed two-stage Rw comparison with per-register pending-write tracking.
- Tracks variable-latency producers (ALU, load, multi-cycle FPU) with per-register countdown counters.
- Generates stall, bypass selects and issue acceptance for the decode stage.
- Sits between instruction decode/control and the ID/EX pipeline register; one instance per register file (GPR, FPR).

---
 rtl/id_scoreboard.sv | 75 +++++++
 tb/tb_id_scoreboard.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/id_scoreboard.sv
// id_scoreboard: per-register pending-write countdown tracking for decode-stage stall and bypass control
module id_scoreboard #(
    parameter int NUM_REGS     = 32,
    parameter int ADDR_W       = 5,
    parameter int LAT_W        = 4,
    parameter int R0_HARDWIRED = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic              issue_wr,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [LAT_W-1:0]  issue_lat,
    input  logic [ADDR_W-1:0] src_a,
    input  logic              src_a_used,
    input  logic [ADDR_W-1:0] src_b,
    input  logic              src_b_used,
    input  logic              flush,
    output logic              stall,
    output logic              issue_accept,
    output logic              fwd_a,
    output logic              fwd_b,
    output logic [ADDR_W:0]   pending
);
    logic [LAT_W-1:0] cnt_q [NUM_REGS];
    logic [LAT_W-1:0] cnt_d [NUM_REGS];
    logic [ADDR_W:0]  pending_q, pending_d;
    logic [LAT_W-1:0] eff_lat, cnt_a, cnt_b, cnt_rd;
    logic             use_a, use_b, raw_a, raw_b, waw, rd_wr;

    always_comb begin
        cnt_a  = '0;
        cnt_b  = '0;
        cnt_rd = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (src_a == ADDR_W'(r)) cnt_a = cnt_q[r];
            if (src_b == ADDR_W'(r)) cnt_b = cnt_q[r];
            if (issue_rd == ADDR_W'(r)) cnt_rd = cnt_q[r];
        end
    end

    assign eff_lat      = (issue_lat == '0) ? LAT_W'(1) : issue_lat;
    assign use_a        = src_a_used & ~((R0_HARDWIRED != 0) && (src_a == '0));
    assign use_b        = src_b_used & ~((R0_HARDWIRED != 0) && (src_b == '0));
    assign raw_a        = use_a & (cnt_a > LAT_W'(1));
    assign raw_b        = use_b & (cnt_b > LAT_W'(1));
    assign fwd_a        = use_a & (cnt_a == LAT_W'(1));
    assign fwd_b        = use_b & (cnt_b == LAT_W'(1));
    // A later producer finishing before an older one would reorder writeback
    assign waw          = issue_wr & (cnt_rd > eff_lat);
    assign stall        = issue_valid & (raw_a | raw_b | waw);
    assign issue_accept = issue_valid & ~stall;
    assign rd_wr        = issue_accept & issue_wr & ~((R0_HARDWIRED != 0) && (issue_rd == '0));
    assign pending      = pending_q;

    always_comb begin
        pending_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r]  = flush ? '0
                      : (rd_wr && issue_rd == ADDR_W'(r)) ? eff_lat
                      : (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
            pending_d = pending_d + ((cnt_d[r] != '0) ? (ADDR_W+1)'(1) : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '{default: '0};
            pending_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end
endmodule

// File: tb/tb_id_scoreboard.sv
// tb_id_scoreboard: GPR and FPR instances driven together, checked against a ready-time model via a scoreboard queue
module tb_id_scoreboard;
    typedef struct packed {
        logic       stall;
        logic       acc;
        logic       fa;
        logic       fb;
        logic [5:0] pend;
    } out_t;

    logic       clk = 0;
    logic       reset, issue_valid, issue_wr, src_a_used, src_b_used, flush;
    logic [4:0] issue_rd, src_a, src_b;
    logic [3:0] issue_lat;
    logic       stall_g, acc_g, fa_g, fb_g, stall_f, acc_f, fa_f, fb_f;
    logic [5:0] pend_g, pend_f;

    out_t q[$];
    int   ready[2][32];
    int   now = 0;
    int   n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    id_scoreboard #(.R0_HARDWIRED(1)) u_g (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_wr(issue_wr),
        .issue_rd(issue_rd), .issue_lat(issue_lat), .src_a(src_a), .src_a_used(src_a_used),
        .src_b(src_b), .src_b_used(src_b_used), .flush(flush), .stall(stall_g),
        .issue_accept(acc_g), .fwd_a(fa_g), .fwd_b(fb_g), .pending(pend_g));

    id_scoreboard #(.R0_HARDWIRED(0)) u_f (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_wr(issue_wr),
        .issue_rd(issue_rd), .issue_lat(issue_lat), .src_a(src_a), .src_a_used(src_a_used),
        .src_b(src_b), .src_b_used(src_b_used), .flush(flush), .stall(stall_f),
        .issue_accept(acc_f), .fwd_a(fa_f), .fwd_b(fb_f), .pending(pend_f));

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, now, act, exp);
    endtask

    function automatic int rem(input int i, input int r);
        return (ready[i][r] > now) ? ready[i][r] - now : 0;
    endfunction

    // Outputs for this cycle follow from remaining cycles before the edge; then advance the model
    task automatic step(input bit v, input bit wr, input int rd, input int lat, input int sa,
                        input bit sau, input int sb, input bit sbu, input bit fl = 0,
                        input bit rs = 0, input bit chk = 1);
        out_t e [2];
        @(posedge clk);
        #1;
        issue_valid = v; issue_wr = wr; issue_rd = 5'(rd); issue_lat = 4'(lat);
        src_a = 5'(sa); src_a_used = sau; src_b = 5'(sb); src_b_used = sbu;
        flush = fl; reset = rs;
        for (int i = 0; i < 2; i++) begin
            bit hw = (i == 0);
            bit ua = sau && !(hw && sa == 0);
            bit ub = sbu && !(hw && sb == 0);
            int el = (lat == 0) ? 1 : lat;
            bit st = v && ((ua && rem(i, sa) > 1) || (ub && rem(i, sb) > 1) || (wr && rem(i, rd) > el));
            int p = 0;
            for (int r = 0; r < 32; r++) if (rem(i, r) > 0) p++;
            e[i] = '{stall: st, acc: v && !st, fa: ua && rem(i, sa) == 1,
                     fb: ub && rem(i, sb) == 1, pend: 6'(p)};
            if (rs || fl) begin
                for (int r = 0; r < 32; r++) ready[i][r] = now + 1;
            end else if (v && !st && wr && !(hw && rd == 0)) begin
                ready[i][rd] = now + 1 + el;
            end
        end
        if (chk) begin
            q.push_back(e[0]);
            q.push_back(e[1]);
        end
        now++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (q.size() >= 2) begin
            out_t eg, ef;
            eg = q.pop_front();
            ef = q.pop_front();
            check("g_stall", int'(stall_g), int'(eg.stall));
            check("g_accept", int'(acc_g), int'(eg.acc));
            check("g_fwd_a", int'(fa_g), int'(eg.fa));
            check("g_fwd_b", int'(fb_g), int'(eg.fb));
            check("g_pending", int'(pend_g), int'(eg.pend));
            check("f_stall", int'(stall_f), int'(ef.stall));
            check("f_accept", int'(acc_f), int'(ef.acc));
            check("f_fwd_a", int'(fa_f), int'(ef.fa));
            check("f_fwd_b", int'(fb_f), int'(ef.fb));
            check("f_pending", int'(pend_f), int'(ef.pend));
        end
    end

    initial begin
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 3, 1, 4, 1);
        step(1, 1, 5, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 5, 1, 0, 0);
        step(1, 0, 0, 0, 5, 1, 0, 0);
        step(1, 1, 7, 2, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(1, 1, 8, 1, 0, 0, 7, 1);
        step(1, 1, 9, 6, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++) step(1, 1, 9, 1, 0, 0, 0, 0);
        idle(3);
        step(1, 1, 0, 5, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 0, 1, 0, 0);
        step(1, 1, 6, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 6, 1, 6, 1);
        step(1, 1, 2, 15, 0, 0, 0, 0);
        step(1, 1, 2, 3, 2, 1, 0, 0);
        idle(15);
        for (int m = 0; m < 2; m++) begin
            step(1, 1, 1, 4, 0, 0, 0, 0);
            step(1, 1, 2, 4, 0, 0, 0, 0);
            step(1, 1, 3, 4, 0, 0, 0, 0);
            step(1, 1, 4, 4, 1, 0, 2, 0, m == 0, m == 1);
            step(1, 0, 0, 0, 1, 1, 2, 1);
            step(1, 0, 0, 0, 3, 1, 4, 1);
        end
        for (int k = 0; k < 500; k++)
            step($urandom % 4 != 0, $urandom % 4 != 0, $urandom % 8, $urandom % 16,
                 $urandom % 8, $urandom % 2 == 1, $urandom % 8, $urandom % 2 == 1,
                 $urandom % 40 == 0, $urandom % 150 == 0);
        idle(2);
        @(negedge clk);
        @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
